maxpool2x2_col: RTL

Streaming 2×2/stride-2 FP16 max-pool stage sitting directly downstream of the edge-detection convolution engine. It consumes one 24-row output column per `col_valid` pulse and emits one 12-row pooled column for every two input columns, so a 24×24 feature map becomes 12×12. It has no backpressure, matching the convolution engine's valid-only column output, and it raises `done` when the last pooled column of a frame is emitted.

---
 rtl/maxpool2x2_col.sv | 96 +++++++++
 1 files changed

// File: rtl/maxpool2x2_col.sv
// maxpool2x2_col: streaming 2x2/stride-2 FP16 max-pool over convolution output columns.
// Even columns are reduced vertically into half_buf; odd columns complete the window and emit.
module maxpool2x2_col #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_ROWS    = 24,
    parameter int IN_COLS    = 24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                col_valid,
    input  logic [IN_ROWS*DATA_WIDTH-1:0]       col_in,
    output logic                                pool_valid,
    output logic [(IN_ROWS/2)*DATA_WIDTH-1:0]   pool_out,
    output logic [$clog2(IN_COLS/2)-1:0]        pool_col_num,
    output logic                                busy,
    output logic                                done,
    output logic                                overrun
);
    localparam int OUT_ROWS = IN_ROWS / 2;
    localparam int OUT_COLS = IN_COLS / 2;
    localparam int CW       = $clog2(IN_COLS);
    localparam int PW       = $clog2(OUT_COLS);
    localparam int OW       = OUT_ROWS * DATA_WIDTH;

    if (IN_ROWS % 2 != 0 || IN_COLS % 2 != 0) begin : g_bad_dims
        $error("maxpool2x2_col: IN_ROWS and IN_COLS must both be even");
    end

    typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

    state_t          state;
    logic [CW-1:0]   in_col_cnt;
    logic [OW-1:0]   half_buf;
    logic [OW-1:0]   vmax;
    logic [OW-1:0]   pmax;
    logic            last;

    // Sign-magnitude ordering: +0 beats -0, NaN/Inf ordered purely by bit pattern.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        logic a_ge;
        a_ge = a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0];
        return (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) ? (a[DATA_WIDTH-1] ? b : a)
             : (a[DATA_WIDTH-1] ? (a_ge ? b : a) : (a_ge ? a : b));
    endfunction

    for (genvar i = 0; i < OUT_ROWS; i++) begin : g_row
        assign vmax[i*DATA_WIDTH +: DATA_WIDTH] = fmax(col_in[(2*i)*DATA_WIDTH +: DATA_WIDTH],
                                                       col_in[(2*i+1)*DATA_WIDTH +: DATA_WIDTH]);
        assign pmax[i*DATA_WIDTH +: DATA_WIDTH] = fmax(half_buf[i*DATA_WIDTH +: DATA_WIDTH],
                                                       vmax[i*DATA_WIDTH +: DATA_WIDTH]);
    end

    assign last = in_col_cnt == CW'(IN_COLS - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            in_col_cnt   <= '0;
            half_buf     <= '0;
            pool_valid   <= 1'b0;
            pool_out     <= '0;
            pool_col_num <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            pool_valid <= 1'b0;
            done       <= 1'b0;
            // The odd column always completes its window, even if start restarts the frame.
            if (state == ODD && col_valid) begin
                pool_out     <= pmax;
                pool_col_num <= PW'(in_col_cnt >> 1);
                pool_valid   <= 1'b1;
                done         <= last;
            end
            if (start) begin
                state      <= col_valid ? ODD : EVEN;
                in_col_cnt <= col_valid ? CW'(1) : '0;
                half_buf   <= col_valid ? vmax : '0;
                overrun    <= 1'b0;
                busy       <= 1'b1;
            end else if (col_valid) begin
                if (state == IDLE) begin
                    overrun <= 1'b1;
                end else begin
                    in_col_cnt <= (state == ODD && last) ? '0 : in_col_cnt + CW'(1);
                    state      <= (state == EVEN) ? ODD : (last ? IDLE : EVEN);
                    if (state == EVEN) half_buf <= vmax;
                    if (state == ODD && last) busy <= 1'b0;
                end
            end
        end
    end
endmodule
